// File: rtl/seq_compare_unit.sv
// +----------------------------------------------------------------------------+
// | seq_compare_unit: multi-cycle LTU/LT/EQ/NE comparator, one CHUNK per cycle |
// | Optional: CMP_EARLY_EXIT_EN (leave RUN on first differing slice)           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_compare_unit #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             kill,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OP_LT = 2'b01;

`ifdef CMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             decided_q, decided_d;
   logic             lt_q, lt_d;
   logic             result_q, result_d;

   logic [WIDTH-1:0] w_sign_mask;
   logic [CHUNK-1:0] w_slice_a;
   logic [CHUNK-1:0] w_slice_b;
   logic             w_diff;
   logic             w_last;

   // Operands shift left each RUN cycle, so the slice under test is always the top CHUNK.
   assign w_sign_mask = {(op == OP_LT), {(WIDTH-1){1'b0}}};
   assign w_slice_a   = a_q[WIDTH-1 -: CHUNK];
   assign w_slice_b   = b_q[WIDTH-1 -: CHUNK];
   assign w_diff      = (w_slice_a != w_slice_b);
   assign w_last      = (idx_q == '0) || (EARLY_EXIT && w_diff);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      idx_d     = idx_q;
      decided_d = decided_q;
      lt_d      = lt_q;
      result_d  = result_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d       = a ^ w_sign_mask;
               b_d       = b ^ w_sign_mask;
               op_d      = op;
               idx_d     = IDX_TOP;
               decided_d = 1'b0;
               lt_d      = 1'b0;
               result_d  = 1'b0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d       = a_q << CHUNK;
            b_d       = b_q << CHUNK;
            decided_d = decided_q | w_diff;
            if (!decided_q && w_diff) begin
               lt_d = (w_slice_a < w_slice_b);
            end
            if (w_last) begin
               state_d  = ST_DONE;
               result_d = op_q[1] ? (op_q[0] ? decided_d : !decided_d)
                                  : (decided_d & lt_d);
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides every transition, including acceptance and output handshake.
      if (kill) begin
         state_d   = ST_IDLE;
         idx_d     = IDX_TOP;
         decided_d = 1'b0;
         lt_d      = 1'b0;
         result_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         idx_q     <= IDX_TOP;
         decided_q <= 1'b0;
         lt_q      <= 1'b0;
         result_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         decided_q <= decided_d;
         lt_q      <= lt_d;
         result_q  <= result_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_compare_unit.sv
// Testbench for seq_compare_unit: vector table, handshake/abort sequences, randomized ops vs reference model.
`default_nettype none

module tb_seq_compare_unit;

   localparam int WIDTH = 64;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             kill = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [1:0]       op = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             result;

   int n_checks = 0;
   int n_fail   = 0;

   seq_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .kill      (kill),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic        exp;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer comparisons.
   function automatic logic model_result(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
      case (o)
         2'b00:   return x < y;
         2'b01:   return $signed(x) < $signed(y);
         2'b10:   return x == y;
         default: return x != y;
      endcase
   endfunction

   // Reference latency: slices examined before the answer is known.
   function automatic int model_latency(input logic [63:0] x, input logic [63:0] y);
`ifdef CMP_EARLY_EXIT_EN
      int j = 1;
      for (int s = N - 1; s > 0; s--) begin
         if (x[s*CHUNK +: CHUNK] != y[s*CHUNK +: CHUNK]) break;
         j++;
      end
      return j;
`else
      return N;
`endif
   endfunction

   task automatic wait_done(input string name, output int lat);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         lat++;
         if (out_valid) return;
      end
      check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic exp);
      int lat;
      check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      op = 2'($urandom);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      wait_done(name, lat);
      check({name, "_result"}, {63'd0, result}, {63'd0, exp});
      check({name, "_latency"}, 64'(lat), 64'(model_latency(x, y)));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_release"}, {62'd0, out_valid, in_ready}, 64'b01);
   endtask

   initial begin
      int lat;
      vecs[0]  = '{"ltu_10_20",    2'b00, 64'd10, 64'd20, 1'b1};
      vecs[1]  = '{"ltu_ones_0",   2'b00, '1, 64'd0, 1'b0};
      vecs[2]  = '{"lt_m1_0",      2'b01, '1, 64'd0, 1'b1};
      vecs[3]  = '{"ltu_0_ones",   2'b00, 64'd0, '1, 1'b1};
      vecs[4]  = '{"eq_25",        2'b10, 64'd25, 64'd25, 1'b1};
      vecs[5]  = '{"ne_25",        2'b11, 64'd25, 64'd25, 1'b0};
      vecs[6]  = '{"eq_0",         2'b10, 64'd0, 64'd0, 1'b1};
      vecs[7]  = '{"ne_0",         2'b11, 64'd0, 64'd0, 1'b0};
      vecs[8]  = '{"lt_0_m1",      2'b01, 64'd0, '1, 1'b0};
      vecs[9]  = '{"lt_min_max",   2'b01, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[10] = '{"ltu_min_max",  2'b00, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[11] = '{"ne_lowbit",    2'b11, 64'h1234_0000_0000_0001, 64'h1234_0000_0000_0000, 1'b1};

      // Reset state; handshake attempts are ignored while reset is held.
      in_valid = 1'b1;
      tick();
      tick();
      check("rst_state", {61'd0, in_ready, out_valid, result}, 64'b100);
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Backpressure: result holds, busy-time requests are dropped.
      op = 2'b00; a = 64'd100; b = 64'd200; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_done("bp", lat);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         op = 2'b10;
         a = {$urandom, $urandom};
         b = a;
         check($sformatf("bp_hold%0d", c), {61'd0, out_valid, result, in_ready}, 64'b110);
         tick();
      end
      in_valid = 1'b0;
      check("bp_hold_end", {61'd0, out_valid, result, in_ready}, 64'b110);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release", {62'd0, out_valid, in_ready}, 64'b01);
      run_op("bp_next", 2'b00, 64'd200, 64'd100, 1'b0);

      // Asynchronous reset mid-RUN.
      op = 2'b00; a = 64'd30; b = 64'd15; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_abort", {61'd0, out_valid, in_ready, result}, 64'b010);
      tick();
      rst_n = 1'b1;
      tick();
      run_op("rst_after", 2'b00, 64'd15, 64'd30, 1'b1);

      // Kill mid-RUN.
      op = 2'b00; a = 64'd30; b = 64'd15; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill_run", {61'd0, out_valid, in_ready, result}, 64'b010);
      run_op("kill_after", 2'b00, 64'd15, 64'd30, 1'b1);

      // Kill in DONE with a pending 1 result and out_ready high.
      op = 2'b00; a = 64'd10; b = 64'd20; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_done("kdone", lat);
      check("kdone_pre", {63'd0, result}, 64'd1);
      kill = 1'b1; out_ready = 1'b1;
      tick();
      kill = 1'b0; out_ready = 1'b0;
      check("kill_done", {61'd0, out_valid, in_ready, result}, 64'b010);

      // Kill on the acceptance edge wins; requester retries.
      op = 2'b10; a = 64'd7; b = 64'd7; in_valid = 1'b1; kill = 1'b1;
      tick();
      kill = 1'b0; in_valid = 1'b0;
      check("kill_accept", {62'd0, in_ready, out_valid}, 64'b10);
      tick();
      check("kill_accept_idle", {62'd0, in_ready, out_valid}, 64'b10);
      run_op("kill_retry", 2'b10, 64'd7, 64'd7, 1'b1);

      // Randomized operations, biased toward shared leading slices.
      for (int i = 0; i < 200; i++) begin
         logic [63:0] x, y;
         logic [1:0]  o;
         int          mode;
         o    = 2'($urandom);
         x    = {$urandom, $urandom};
         mode = $urandom_range(0, 2);
         if (mode == 0) y = {$urandom, $urandom};
         else if (mode == 1) y = x;
         else y = x ^ ({$urandom, $urandom} >> (CHUNK * $urandom_range(1, N - 1)));
         run_op($sformatf("rnd%0d", i), o, x, y, model_result(o, x, y));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, limit 2000000 expected");
      $fatal(1);
   end

endmodule

`default_nettype wire
